// File: rtl/uart_tx_frame.sv
// Buffered 8N1 UART transmitter: rising-edge byte strobe into a small FIFO,
// serialised LSB first on a registered Tx line at CLK/BAUD_DIV bits per second.
module uart_tx_frame #(
    parameter int unsigned BAUD_DIV = 434,
    parameter int unsigned FIFO_AW  = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       DataLock,
    input  logic [7:0] Send,
    output logic       Tx,
    output logic       Busy,
    output logic       Full,
    output logic       Overflow
);
    localparam int unsigned      DEPTH      = 1 << FIFO_AW;
    localparam logic [15:0]      TICK_MAX   = 16'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] COUNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

    stateT              state;
    stateT              stateNext;
    logic [15:0]        baudCnt;
    logic [2:0]         bitIdx;
    logic [7:0]         Sh;
    logic [7:0]         fifoMem [DEPTH];
    logic [FIFO_AW-1:0] wrPtr;
    logic [FIFO_AW-1:0] rdPtr;
    logic [FIFO_AW:0]   count;
    logic               DataLockD;
    logic               Wr;
    logic               BitTick;
    logic               fifoEmpty;
    logic               pop;
    logic               bitAdvance;
    logic               wrAccept;
    logic               wrDrop;
    logic               txNext;

    // Strobe contract: there is no ready back to the source. Each rising edge of
    // DataLock offers one byte (Send in that cycle); it is queued if room exists
    // (or a pop frees a slot in the same cycle), otherwise dropped and Overflow latches.
    assign Wr        = DataLock & ~DataLockD;
    assign fifoEmpty = (count == '0);
    assign Full      = (count == COUNT_FULL);
    assign BitTick   = (baudCnt == TICK_MAX);
    assign Busy      = (state != IDLE) || !fifoEmpty;
    assign wrAccept  = Wr & (!Full | pop);
    assign wrDrop    = Wr & Full & !pop;

    always_comb begin
        stateNext  = state;
        pop        = 1'b0;
        bitAdvance = 1'b0;
        txNext     = 1'b1;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    stateNext = START;
                end
            end
            START: begin
                txNext = 1'b0;
                if (BitTick) stateNext = DATA;
            end
            DATA: begin
                txNext = Sh[0];
                if (BitTick) begin
                    bitAdvance = 1'b1;
                    if (bitIdx == 3'd7) stateNext = STOP;
                end
            end
            STOP: begin
                // A queued byte starts its frame straight from the stop bit: no idle gap.
                if (BitTick) begin
                    if (!fifoEmpty) begin
                        pop       = 1'b1;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            baudCnt   <= '0;
            bitIdx    <= '0;
            Sh        <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            DataLockD <= 1'b0;
            Tx        <= 1'b1;
            Overflow  <= 1'b0;
        end else begin
            state     <= stateNext;
            DataLockD <= DataLock;
            Tx        <= txNext;

            // Every non-IDLE transition lands on BitTick, so this also restarts the bit timer.
            if (state == IDLE || BitTick) baudCnt <= '0;
            else                          baudCnt <= baudCnt + 16'd1;

            if (bitAdvance)         bitIdx <= bitIdx + 3'd1;
            else if (state != DATA) bitIdx <= '0;

            if (pop)             Sh <= fifoMem[rdPtr];
            else if (bitAdvance) Sh <= {1'b0, Sh[7:1]};

            if (wrAccept) wrPtr <= wrPtr + PTR_ONE;
            if (pop)      rdPtr <= rdPtr + PTR_ONE;

            if (wrAccept && !pop)      count <= count + COUNT_ONE;
            else if (pop && !wrAccept) count <= count - COUNT_ONE;

            if (wrDrop) Overflow <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (wrAccept) fifoMem[wrPtr] <= Send;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Buffered 8N1 UART transmitter for the ECT host link. Consumes the arbitrated byte strobe (`DataLock`) and byte (`Send`) from the UART source-selection stage directly upstream. Queues bytes in a small FIFO and serialises them onto `Tx`, LSB first, at a fixed baud derived from the system clock.

## Interface
- `BAUD_DIV`, default 434 — clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- `FIFO_AW`, default 2 — FIFO address width; depth = 2^FIFO_AW = 4 bytes.
- `Clk` in 1 — system clock; all logic rising-edge.
- `Rst` in 1 — asynchronous, active-high reset.
- `DataLock` in 1 — byte strobe from the arbitration stage; rising edge captures `Send`.
- `Send` in 8 — byte to transmit; sampled on the `DataLock` rising-edge cycle.
- `Tx` out 1 — serial line, registered; idle high.
- `Busy` out 1 — high while the FSM is not IDLE or the FIFO is non-empty.
- `Full` out 1 — FIFO holds 2^FIFO_AW bytes.
- `Overflow` out 1 — sticky; set when a captured byte is dropped. Cleared only by `Rst`.

## Operation
- **Edge detect:** register `DataLockD` (reset 0). Write request `Wr = DataLock & ~DataLockD`.
  - Holding `DataLock` high yields exactly one write.
  - If `DataLock` is high when reset releases, one write occurs on the first clock.
- **FIFO:** circular buffer with `FIFO_AW`-bit read/write pointers (wrap naturally) and a `FIFO_AW+1`-bit count.
  - Write accepted if `!Full`, or if a pop occurs in the same cycle (count unchanged).
  - Otherwise the byte is dropped and `Overflow` is set; FIFO contents are untouched.
  - Simultaneous write and pop on an empty FIFO cannot happen, because pop requires non-empty.
- **Baud counter:** 16-bit, counts 0..BAUD_DIV-1 in every non-IDLE state. `BitTick` = counter at BAUD_DIV-1. The counter resets to 0 on every state or bit change.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `Tx`=1. If FIFO non-empty, pop the head into shift register `Sh[7:0]` and go to START.
  - **START:** `Tx`=0 for BAUD_DIV cycles; on `BitTick` go to DATA with bit index 0.
  - **DATA:** `Tx`=`Sh[0]`. On `BitTick`, shift right and increment the index. After index 7's `BitTick`, go to STOP.
  - **STOP:** `Tx`=1 for BAUD_DIV cycles. On `BitTick`:
    - if FIFO non-empty, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- `Send` changes after capture have no effect on a queued or in-flight byte.
- `Busy` is combinational from registered state and count. `Full` = (count == 2^FIFO_AW).

## Timing
- **Reset values:** `Tx`=1, `Busy`=0, `Full`=0, `Overflow`=0, FSM=IDLE, pointers/count=0, `DataLockD`=0.
- **Reset mid-frame:** the frame is aborted and `Tx` goes high asynchronously. FIFO contents are discarded; no partial byte resumes.
- **Latency:**
  - `DataLock` rises, sampled at edge k; byte written at edge k.
  - IDLE pops at edge k+1; `Tx` falls at edge k+2 (registered output).
  - `Busy` rises after edge k.
- **Frame length:** exactly 10·BAUD_DIV cycles (start, 8 data, stop).
- **Back-to-back frames:** next start-bit falling edge occurs exactly 10·BAUD_DIV cycles after the previous one.
- **Busy fall:** `Busy` falls in the cycle after the final stop bit's `BitTick` when the FIFO is empty. `Tx` stays 1.
- **Throughput bound:** one write per 2 cycles (edge detection). Up to 2^FIFO_AW bytes queue while one frame is also in flight in `Sh`, i.e. 5 bytes accepted before the first drop.

## Test plan
1. **Single byte** (BAUD_DIV=4): reset, pulse `DataLock` 1 cycle with `Send`=0xA5.
   - `Tx` low 2 cycles after capture, then bits 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each, then stop high.
   - `Busy` drops 40 cycles after the start edge.
2. **Held strobe:** `DataLock` held high for 50 cycles with `Send`=0x3C → exactly one frame of 0x3C; `Overflow`=0.
3. **Burst/overflow:** 6 strobes, 2 cycles apart, bytes 0x01..0x06.
   - 0x01 goes in flight; 0x02–0x05 fill the FIFO (`Full`=1); 0x06 is dropped and `Overflow`=1.
   - Five contiguous frames 0x01..0x05, each start 40 cycles apart, no idle gap.
4. **Write on pop:** with FIFO full, strobe 0x77 in the same cycle as the STOP→START pop → 0x77 accepted, transmitted last, `Overflow` unchanged.
5. **Mid-frame reset:** assert `Rst` during DATA bit 3 of 0x0F.
   - `Tx`=1 immediately; `Busy`=0; all outputs at reset values.
   - No residual frame after release; a new 0x81 then transmits correctly.
6. **Wrap-around:** 12 single bytes, each sent after the previous frame completes → pointers wrap 3 times; all 12 bytes received in order.
